// File: rtl/power_gate_sequencer_if.sv
// power_gate_sequencer_if: target request and per-domain power/isolation status bundle.
interface power_gate_sequencer_if;
  logic [2:0] target_on;
  logic [2:0] power_en;
  logic [2:0] iso_en;
  logic [2:0] power_good;
  logic       busy;
  logic [1:0] active_domain;
  logic       done;
  modport master (
    output target_on,
    input  power_en, iso_en, power_good, busy, active_domain, done
  );
  modport slave (
    input  target_on,
    output power_en, iso_en, power_good, busy, active_domain, done
  );
endinterface

// File: rtl/power_gate_sequencer.sv
// power_gate_sequencer: one-domain-at-a-time timed isolation/power sequencing for conv, pool, fc.
module power_gate_sequencer #(
  parameter int PWR_UP_CYCLES = 4,
  parameter int ISO_CYCLES    = 2
) (
  input logic clk,
  input logic reset,
  power_gate_sequencer_if.slave bus
);
  localparam int MAX_C = (PWR_UP_CYCLES > ISO_CYCLES) ? PWR_UP_CYCLES : ISO_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  typedef enum logic [1:0] {IDLE, UP_WAIT, DN_WAIT} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    pen, pen_n, iso, iso_n, mm;
  logic [1:0]    ad, ad_n, sel;
  logic          done_q, done_n;
  // A domain sitting powered but isolated with target on still counts as mismatched.
  assign mm  = (bus.target_on & ~(pen & ~iso)) | (~bus.target_on & pen);
  assign sel = mm[0] ? 2'd0 : mm[1] ? 2'd1 : 2'd2;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pen    <= 3'b000;
      iso    <= 3'b111;
      ad     <= 2'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pen    <= pen_n;
      iso    <= iso_n;
      ad     <= ad_n;
      done_q <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pen_n   = pen;
    iso_n   = iso;
    ad_n    = ad;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (|mm) begin
        ad_n = sel;
        if (bus.target_on[sel]) begin
          pen_n[sel] = 1'b1;
          cnt_n      = CW'(PWR_UP_CYCLES - 1);
          state_n    = UP_WAIT;
        end else begin
          iso_n[sel] = 1'b1;
          cnt_n      = CW'(ISO_CYCLES - 1);
          state_n    = DN_WAIT;
        end
      end
      UP_WAIT: if (cnt != '0) cnt_n = cnt - 1'b1;
      else begin
        iso_n[ad] = 1'b0;
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      DN_WAIT: if (cnt != '0) cnt_n = cnt - 1'b1;
      else begin
        pen_n[ad] = 1'b0;
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.power_en      = pen;
  assign bus.iso_en        = iso;
  assign bus.power_good    = pen & ~iso;
  assign bus.busy          = state != IDLE;
  assign bus.active_domain = ad;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_power_gate_sequencer.sv
// tb_power_gate_sequencer: directed plan steps plus random traffic against a completion-time reference model.
module tb_power_gate_sequencer;
  localparam int PU  = 4;
  localparam int ISO = 2;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  power_gate_sequencer_if bus();
  power_gate_sequencer #(.PWR_UP_CYCLES(PU), .ISO_CYCLES(ISO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  logic [2:0] m_pen, m_iso;
  logic [1:0] m_ad;
  logic       m_busy, m_done, m_up;
  int         cyc = 0;
  int         fin = 0;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Sequences are modelled by their completion edge, not by a down-counter.
  task automatic model_edge(input logic [2:0] t, input logic r);
    logic [2:0] mm;
    logic found;
    cyc++;
    if (r) begin
      m_pen = 3'b000; m_iso = 3'b111; m_busy = 0; m_ad = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (cyc == fin) begin
          if (m_up) m_iso[m_ad] = 1'b0;
          else m_pen[m_ad] = 1'b0;
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        mm = (t & ~(m_pen & ~m_iso)) | (~t & m_pen);
        found = 0;
        for (int d = 0; d < 3; d++)
          if (!found && mm[d]) begin
            found = 1;
            m_ad = 2'(d);
            m_up = t[d];
            if (t[d]) begin m_pen[d] = 1'b1; fin = cyc + PU; end
            else begin m_iso[d] = 1'b1; fin = cyc + ISO; end
            m_busy = 1;
          end
      end
    end
  endtask
  task automatic tick(input logic [2:0] t, input logic r);
    bus.target_on = t;
    reset = r;
    @(posedge clk);
    model_edge(t, r);
    @(negedge clk);
    chk("power_en", bus.power_en, m_pen);
    chk("iso_en", bus.iso_en, m_iso);
    chk("power_good", bus.power_good, m_pen & ~m_iso);
    chk("busy", bus.busy, m_busy);
    chk("active_domain", bus.active_domain, m_ad);
    chk("done", bus.done, m_done);
    chk("no_off_unisolated", |(~bus.power_en & ~bus.iso_en), 1'b0);
  endtask
  task automatic run(input logic [2:0] t, input int n);
    for (int i = 0; i < n; i++) tick(t, 1'b0);
  endtask
  initial begin
    logic [2:0] tg;
    tg = 3'b000;
    tick(3'b000, 1'b1);
    tick(3'b000, 1'b1);
    run(3'b000, 10);
    chk("idle_iso", bus.iso_en, 3'b111);
    run(3'b001, 5);
    chk("conv_up_pg", bus.power_good, 3'b001);
    chk("conv_up_done", bus.done, 1'b1);
    run(3'b111, 10);
    chk("all_up_pg", bus.power_good, 3'b111);
    chk("all_up_done", bus.done, 1'b1);
    run(3'b011, 3);
    chk("fc_dn_ad", bus.active_domain, 2'd2);
    chk("fc_dn_pen", bus.power_en, 3'b011);
    chk("fc_dn_done", bus.done, 1'b1);
    run(3'b010, 4);
    chk("conv_off_pen", bus.power_en, 3'b010);
    run(3'b011, 2);
    run(3'b010, 3);
    chk("rev_up_done", bus.done, 1'b1);
    chk("rev_up_iso0", bus.iso_en[0], 1'b0);
    run(3'b010, 1);
    chk("rev_dn_iso0", bus.iso_en[0], 1'b1);
    run(3'b010, 2);
    chk("rev_dn_pen0", bus.power_en[0], 1'b0);
    run(3'b000, 4);
    run(3'b010, 3);
    chk("pool_mid_busy", bus.busy, 1'b1);
    tick(3'b010, 1'b1);
    chk("rst_pen", bus.power_en, 3'b000);
    chk("rst_iso", bus.iso_en, 3'b111);
    chk("rst_busy", bus.busy, 1'b0);
    run(3'b010, 6);
    chk("restart_pg", bus.power_good, 3'b010);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) tg = 3'($urandom_range(0, 7));
      tick(tg, $urandom_range(0, 60) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
